// File: rtl/ad9783_pkg.sv
// AD9783 SPI responder shared definitions.
// Instruction layout, register map constants, reset defaults, FSM states.
package ad9783_pkg;

  localparam int INSTR_RW_BIT   = 7;
  localparam int INSTR_N_MSB    = 6;
  localparam int INSTR_N_LSB    = 5;
  localparam int INSTR_ADDR_MSB = 4;

  localparam logic       RW_READ      = 1'b1;
  localparam logic [4:0] ADDR_REV     = 5'h1F;
  localparam logic [4:0] ADDR_CTRL    = 5'h00;
  localparam int         SOFT_RST_BIT = 5;

  localparam logic [7:0] REG_DEFAULTS [32] = '{
    8'h00, 8'h00, 8'h80, 8'h00, 8'h34, 8'h1C, 8'h0F, 8'h0F,
    8'h00, 8'h00, 8'hEF, 8'h01, 8'h00, 8'h00, 8'h55, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INSTR,
    ST_WDATA,
    ST_RDATA,
    ST_DONE
  } spi_state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-stage synchronizer for an asynchronous pin.
// Emits the synchronized level plus registered rise/fall pulses.
module spi_edge_sync #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              r_rise;
  logic              r_fall;

  // Synchronize pin, then compare against previous level for edges
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_sync <= {STAGES{INIT}};
      r_prev <= INIT;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
      r_rise <= r_sync[STAGES-1] & ~r_prev;
      r_fall <= ~r_sync[STAGES-1] & r_prev;
    end
  end

  assign o_level = r_prev;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/ad9783_spi_responder.sv
// AD9783-style SPI register-port responder with a 32x8 register file.
// Serves SPI writes/reads and exposes the register file to local logic.
module ad9783_spi_responder
  import ad9783_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] REV_ID      = 8'h03
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       spi_scs_in,
  input  logic       spi_sck_in,
  input  logic       spi_sdi_in,
  output logic       spi_sdo_out,
  output logic       spi_sdo_oe_out,
  input  logic [4:0] reg_addr_in,
  output logic [7:0] reg_data_out,
  output logic       wr_stb_out,
  output logic [4:0] wr_addr_out,
  output logic [7:0] wr_data_out
);

  logic w_scs_lvl, w_scs_rise, w_scs_fall;
  logic w_sck_lvl, w_sck_rise, w_sck_fall;
  logic w_sdi, w_sdi_rise, w_sdi_fall;
  logic w_unused;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_scs (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .i_d    (spi_scs_in),
    .o_level(w_scs_lvl),
    .o_rise (w_scs_rise),
    .o_fall (w_scs_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sck (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .i_d    (spi_sck_in),
    .o_level(w_sck_lvl),
    .o_rise (w_sck_rise),
    .o_fall (w_sck_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sdi (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .i_d    (spi_sdi_in),
    .o_level(w_sdi),
    .o_rise (w_sdi_rise),
    .o_fall (w_sdi_fall)
  );

  assign w_unused = ^{w_scs_lvl, w_sck_lvl, w_sdi_rise, w_sdi_fall};

  spi_state_e r_state;
  logic [2:0] r_bitcnt;
  logic [6:0] r_shift;
  logic [1:0] r_nleft;
  logic [4:0] r_addr;
  logic [7:0] r_sdo_sr;
  logic       r_sdo;
  logic       r_oe;
  logic       r_wr_stb;
  logic [4:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic       r_soft_rst;
  logic [7:0] r_regs [32];

  logic [7:0] w_shift_nx;
  logic [4:0] w_instr_addr;
  logic       w_scs_evt;
  logic       w_commit;

  function automatic logic [7:0] rd_reg(input logic [4:0] a);
    return (a == ADDR_REV) ? REV_ID : r_regs[a];
  endfunction

  assign w_shift_nx   = {r_shift, w_sdi};
  assign w_instr_addr = w_shift_nx[INSTR_ADDR_MSB:0];
  assign w_scs_evt    = w_scs_fall | w_scs_rise;
  assign w_commit     = (r_state == ST_WDATA) && w_sck_rise &&
                        (r_bitcnt == 3'd7) && (r_addr != ADDR_REV) &&
                        !w_scs_evt;

  // Register file: reset/soft-reset defaults, SPI byte commits
  always_ff @(posedge clk_in) begin
    if (!rst_in || r_soft_rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= REG_DEFAULTS[i];
    end else if (w_commit) begin
      r_regs[r_addr] <= w_shift_nx;
    end
  end

  // SPI transaction sequencing, shifters and registered outputs
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state    <= ST_IDLE;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_nleft    <= '0;
      r_addr     <= '0;
      r_sdo_sr   <= '0;
      r_sdo      <= 1'b0;
      r_oe       <= 1'b0;
      r_wr_stb   <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_soft_rst <= 1'b0;
    end else begin
      r_wr_stb   <= 1'b0;
      r_soft_rst <= 1'b0;
      if (w_commit) begin
        r_wr_stb   <= 1'b1;
        r_wr_addr  <= r_addr;
        r_wr_data  <= w_shift_nx;
        r_soft_rst <= (r_addr == ADDR_CTRL) &&
                      w_shift_nx[SOFT_RST_BIT];
      end
      if (w_scs_evt) begin
        r_state  <= w_scs_fall ? ST_INSTR : ST_IDLE;
        r_bitcnt <= '0;
        r_oe     <= 1'b0;
        r_sdo    <= 1'b0;
      end else begin
        unique case (r_state)
          ST_INSTR: begin
            if (w_sck_rise) begin
              r_shift  <= w_shift_nx[6:0];
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                r_nleft <= w_shift_nx[INSTR_N_MSB:INSTR_N_LSB];
                r_addr  <= w_instr_addr;
                if (w_shift_nx[INSTR_RW_BIT] == RW_READ) begin
                  r_state  <= ST_RDATA;
                  r_sdo_sr <= rd_reg(w_instr_addr);
                  r_oe     <= 1'b1;
                end else begin
                  r_state <= ST_WDATA;
                end
              end
            end
          end
          ST_WDATA: begin
            if (w_sck_rise) begin
              r_shift  <= w_shift_nx[6:0];
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                r_addr <= r_addr - 5'd1;
                if (r_nleft == 2'd0) r_state <= ST_DONE;
                else r_nleft <= r_nleft - 2'd1;
              end
            end
          end
          ST_RDATA: begin
            if (w_sck_fall) begin
              r_sdo <= r_sdo_sr[7];
              if (r_bitcnt == 3'd7) begin
                r_sdo_sr <= rd_reg(r_addr - 5'd1);
                r_addr   <= r_addr - 5'd1;
              end else begin
                r_sdo_sr <= {r_sdo_sr[6:0], 1'b0};
              end
            end else if (w_sck_rise) begin
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                if (r_nleft == 2'd0) begin
                  r_state <= ST_DONE;
                  r_oe    <= 1'b0;
                  r_sdo   <= 1'b0;
                end else begin
                  r_nleft <= r_nleft - 2'd1;
                end
              end
            end
          end
          ST_IDLE, ST_DONE: begin
          end
        endcase
      end
    end
  end

  assign spi_sdo_out    = r_sdo;
  assign spi_sdo_oe_out = r_oe;
  assign reg_data_out   = rd_reg(reg_addr_in);
  assign wr_stb_out     = r_wr_stb;
  assign wr_addr_out    = r_wr_addr;
  assign wr_data_out    = r_wr_data;

endmodule

// File: tb/tb_ad9783_spi_responder.sv
// Self-checking bench for ad9783_spi_responder.
// Directed SPI frames plus random frames against a register-map model.
module tb_ad9783_spi_responder;

  localparam int         HP  = 8;
  localparam logic [7:0] REV = 8'h03;
  localparam logic [7:0] DEF [32] = '{
    8'h00, 8'h00, 8'h80, 8'h00, 8'h34, 8'h1C, 8'h0F, 8'h0F,
    8'h00, 8'h00, 8'hEF, 8'h01, 8'h00, 8'h00, 8'h55, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scs, sck, sdi;
  logic       sdo, oe;
  logic [4:0] raddr;
  logic [7:0] rdata;
  logic       stb;
  logic [4:0] waddr;
  logic [7:0] wdata;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  m_regs [32];
  int          stb_cnt = 0;
  logic [63:0] stb_log = '0;

  always #5 clk = ~clk;

  ad9783_spi_responder #(.SYNC_STAGES(2), .REV_ID(8'h03)) dut (
    .clk_in        (clk),
    .rst_in        (rst_n),
    .spi_scs_in    (scs),
    .spi_sck_in    (sck),
    .spi_sdi_in    (sdi),
    .spi_sdo_out   (sdo),
    .spi_sdo_oe_out(oe),
    .reg_addr_in   (raddr),
    .reg_data_out  (rdata),
    .wr_stb_out    (stb),
    .wr_addr_out   (waddr),
    .wr_data_out   (wdata)
  );

  // Log every strobe cycle as {addr,data}
  always @(negedge clk) begin
    if (stb) begin
      stb_cnt <= stb_cnt + 1;
      stb_log <= {stb_log[50:0], waddr, wdata};
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = DEF[i];
  endtask

  // Register-map view of one frame: expected MISO, OE and strobes
  task automatic model_frame(
    input  logic [7:0]  instr,
    input  logic [31:0] wdat,
    input  int          nbits,
    output logic [39:0] emiso,
    output logic [39:0] eoe,
    output int          ecnt,
    output logic [63:0] elog
  );
    int n;
    int full;
    logic [4:0] a;
    logic [7:0] v;
    n = int'(instr[6:5]) + 1;
    full = (nbits - 8) / 8;
    emiso = '0; eoe = '0; ecnt = 0; elog = '0;
    for (int k = 0; k < 4; k++) begin
      a = instr[4:0] - 5'(k);
      if (k < n) begin
        if (instr[7]) begin
          v = (a == 5'h1F) ? REV : m_regs[a];
          for (int b = 0; b < 8; b++) begin
            if (8 + 8 * k + b < nbits) begin
              emiso[39 - (8 + 8 * k + b)] = v[7 - b];
              eoe[39 - (8 + 8 * k + b)] = 1'b1;
            end
          end
        end else if (k < full && a != 5'h1F) begin
          v = wdat[31 - 8 * k -: 8];
          elog = {elog[50:0], a, v};
          ecnt++;
          m_regs[a] = v;
          if (a == 5'h00 && v[5]) model_reset();
        end
      end
    end
  endtask

  task automatic spi_bit(input logic b, output logic so, output logic os);
    sdi = b;
    repeat (HP) @(negedge clk);
    so = sdo;
    os = oe;
    sck = 1'b1;
    repeat (HP) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic run_frame(
    input  logic [39:0] mosi,
    input  int          nbits,
    output logic [39:0] miso,
    output logic [39:0] oev,
    output int          cnt,
    output logic [63:0] log
  );
    int c0;
    logic so, os;
    c0 = stb_cnt;
    miso = '0; oev = '0;
    scs = 1'b0;
    repeat (HP) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_bit(mosi[39 - i], so, os);
      miso[39 - i] = so;
      oev[39 - i] = os;
    end
    repeat (HP) @(negedge clk);
    scs = 1'b1;
    repeat (2 * HP) @(negedge clk);
    cnt = stb_cnt - c0;
    log = stb_log;
  endtask

  task automatic read_local(input logic [4:0] a, output logic [7:0] v);
    raddr = a;
    #1;
    v = rdata;
  endtask

  task automatic test_reset();
    logic [7:0] v, e;
    rst_n = 1'b0; scs = 1'b1; sck = 1'b0; sdi = 1'b0; raddr = '0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    model_reset();
    n_tests++;
    if ({sdo, oe, stb, waddr, wdata} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outs got %h want 0000", {sdo, oe, stb, waddr, wdata});
    end
    for (int i = 0; i < 32; i++) begin
      read_local(5'(i), v);
      e = (i == 31) ? REV : DEF[i];
      n_tests++;
      if (v !== e) begin
        n_fail++;
        $display("FAIL reset_reg[%0d] got %h want %h", i, v, e);
      end
    end
  endtask

  task automatic test_write_one();
    logic [39:0] mi, ov, emi, eov;
    int c, ec;
    logic [63:0] lg, elg;
    logic [7:0] v;
    model_frame(8'h05, 32'hA500_0000, 16, emi, eov, ec, elg);
    run_frame({8'h05, 8'hA5, 24'h0}, 16, mi, ov, c, lg);
    read_local(5'h05, v);
    n_tests++;
    if (c !== 1 || lg[12:0] !== {5'h05, 8'hA5}) begin
      n_fail++;
      $display("FAIL wr1_strobe got n=%0d %h want n=1 %h", c, lg[12:0], {5'h05, 8'hA5});
    end
    n_tests++;
    if (v !== 8'hA5) begin
      n_fail++;
      $display("FAIL wr1_reg got %h want a5", v);
    end
    n_tests++;
    if (mi !== emi || ov !== eov) begin
      n_fail++;
      $display("FAIL wr1_sdo got %h/%h want %h/%h", mi, ov, emi, eov);
    end
  endtask

  task automatic test_write_three();
    logic [39:0] mi, ov, emi, eov;
    int c, ec;
    logic [63:0] lg, elg;
    logic [7:0] v0, v1, v2;
    model_frame(8'h42, 32'h1122_1300, 32, emi, eov, ec, elg);
    run_frame({8'h42, 8'h11, 8'h22, 8'h13, 8'h00}, 32, mi, ov, c, lg);
    read_local(5'h02, v2);
    read_local(5'h01, v1);
    read_local(5'h00, v0);
    n_tests++;
    if (c !== 3 || lg[38:0] !== {5'h02, 8'h11, 5'h01, 8'h22, 5'h00, 8'h13}) begin
      n_fail++;
      $display("FAIL wr3_strobes got n=%0d %h", c, lg[38:0]);
    end
    n_tests++;
    if ({v2, v1, v0} !== 24'h112213) begin
      n_fail++;
      $display("FAIL wr3_regs got %h want 112213", {v2, v1, v0});
    end
  endtask

  task automatic test_read_two();
    logic [39:0] mi, ov, emi, eov;
    int c, ec;
    logic [63:0] lg, elg;
    model_frame(8'hA2, 32'h0, 24, emi, eov, ec, elg);
    run_frame({8'hA2, 32'h0}, 24, mi, ov, c, lg);
    n_tests++;
    if (mi[31:16] !== 16'h1122 || mi !== emi) begin
      n_fail++;
      $display("FAIL rd2_data got %h want %h", mi, emi);
    end
    n_tests++;
    if (ov !== 40'h00FFFF0000 || c !== 0) begin
      n_fail++;
      $display("FAIL rd2_oe got %h n=%0d want 00ffff0000 n=0", ov, c);
    end
  endtask

  task automatic test_rev();
    logic [39:0] mi, ov, emi, eov;
    int c, ec;
    logic [63:0] lg, elg;
    logic [7:0] v;
    model_frame(8'h9F, 32'h0, 16, emi, eov, ec, elg);
    run_frame({8'h9F, 32'h0}, 16, mi, ov, c, lg);
    n_tests++;
    if (mi[31:24] !== 8'h03) begin
      n_fail++;
      $display("FAIL rev_read got %h want 03", mi[31:24]);
    end
    model_frame(8'h1F, 32'hFF00_0000, 16, emi, eov, ec, elg);
    run_frame({8'h1F, 8'hFF, 24'h0}, 16, mi, ov, c, lg);
    read_local(5'h1F, v);
    n_tests++;
    if (c !== 0 || v !== 8'h03) begin
      n_fail++;
      $display("FAIL rev_write got n=%0d reg=%h want n=0 reg=03", c, v);
    end
  endtask

  task automatic test_abort();
    logic [39:0] mi, ov, emi, eov;
    int c, ec;
    logic [63:0] lg, elg;
    logic [7:0] v;
    model_frame(8'h07, 32'hC000_0000, 12, emi, eov, ec, elg);
    run_frame({8'h07, 8'hC0, 24'h0}, 12, mi, ov, c, lg);
    read_local(5'h07, v);
    n_tests++;
    if (c !== 0 || v !== DEF[7]) begin
      n_fail++;
      $display("FAIL abort got n=%0d reg=%h want n=0 reg=%h", c, v, DEF[7]);
    end
    model_frame(8'h07, 32'h5A00_0000, 16, emi, eov, ec, elg);
    run_frame({8'h07, 8'h5A, 24'h0}, 16, mi, ov, c, lg);
    read_local(5'h07, v);
    n_tests++;
    if (c !== 1 || lg[12:0] !== {5'h07, 8'h5A} || v !== 8'h5A) begin
      n_fail++;
      $display("FAIL after_abort got n=%0d %h reg=%h want n=1 %h reg=5a", c, lg[12:0], v, {5'h07, 8'h5A});
    end
  endtask

  task automatic test_soft_reset();
    logic [39:0] mi, ov, emi, eov;
    int c, ec;
    logic [63:0] lg, elg;
    logic [7:0] v, e;
    model_frame(8'h00, 32'h2000_0000, 16, emi, eov, ec, elg);
    run_frame({8'h00, 8'h20, 24'h0}, 16, mi, ov, c, lg);
    n_tests++;
    if (c !== 1 || lg[12:0] !== {5'h00, 8'h20}) begin
      n_fail++;
      $display("FAIL soft_strobe got n=%0d %h want n=1 %h", c, lg[12:0], {5'h00, 8'h20});
    end
    for (int i = 0; i < 32; i++) begin
      read_local(5'(i), v);
      e = (i == 31) ? REV : DEF[i];
      n_tests++;
      if (v !== e) begin
        n_fail++;
        $display("FAIL soft_reg[%0d] got %h want %h", i, v, e);
      end
    end
  endtask

  task automatic test_rst_mid_read();
    logic [39:0] mi, ov, emi, eov;
    int c, ec;
    logic [63:0] lg, elg;
    logic [7:0] instr, v, e;
    logic so, os;
    model_frame(8'h05, 32'h6B00_0000, 16, emi, eov, ec, elg);
    run_frame({8'h05, 8'h6B, 24'h0}, 16, mi, ov, c, lg);
    instr = 8'hA5;
    scs = 1'b0;
    repeat (HP) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      spi_bit(i < 8 ? instr[7 - i] : 1'b0, so, os);
    end
    repeat (4) @(negedge clk);
    n_tests++;
    if (oe !== 1'b1) begin
      n_fail++;
      $display("FAIL midread_oe got %b want 1", oe);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    n_tests++;
    if (oe !== 1'b0 || sdo !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_oe got oe=%b sdo=%b want 0 0", oe, sdo);
    end
    for (int i = 0; i < 32; i++) begin
      read_local(5'(i), v);
      e = (i == 31) ? REV : DEF[i];
      n_tests++;
      if (v !== e) begin
        n_fail++;
        $display("FAIL rst_reg[%0d] got %h want %h", i, v, e);
      end
    end
    rst_n = 1'b1;
    repeat (HP) @(negedge clk);
    scs = 1'b1;
    repeat (2 * HP) @(negedge clk);
  endtask

  task automatic test_random();
    logic [39:0] mi, ov, emi, eov;
    int c, ec, nb;
    logic [63:0] lg, elg, mask;
    logic [7:0] instr, v, e;
    logic [31:0] wd;
    for (int t = 0; t < 25; t++) begin
      instr = 8'($urandom);
      wd = $urandom;
      nb = 8 + $urandom_range(0, 32);
      model_frame(instr, wd, nb, emi, eov, ec, elg);
      run_frame({instr, wd}, nb, mi, ov, c, lg);
      mask = (64'd1 << (13 * ec)) - 64'd1;
      n_tests++;
      if (c !== ec || (lg & mask) !== elg) begin
        n_fail++;
        $display("FAIL rnd%0d_strobes i=%h got n=%0d %h want n=%0d %h", t, instr, c, lg & mask, ec, elg);
      end
      n_tests++;
      if (mi !== emi || ov !== eov) begin
        n_fail++;
        $display("FAIL rnd%0d_sdo i=%h got %h/%h want %h/%h", t, instr, mi, ov, emi, eov);
      end
    end
    for (int i = 0; i < 32; i++) begin
      read_local(5'(i), v);
      e = (i == 31) ? REV : m_regs[i];
      n_tests++;
      if (v !== e) begin
        n_fail++;
        $display("FAIL rnd_reg[%0d] got %h want %h", i, v, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_one();
    test_write_three();
    test_read_two();
    test_rev();
    test_abort();
    test_soft_reset();
    test_rst_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
